// File: rtl/div_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_ctrl_if : link between the EX-stage divide controller and the
//               multi-cycle iterative divider.
//
// Signals
//   div_start   controller -> divider  start request (level, held)
//   div_annul   controller -> divider  cancel in-flight division (1-cycle pulse)
//   div_signed  controller -> divider  1 = signed divide
//   div_op1     controller -> divider  dividend, latched at issue
//   div_op2     controller -> divider  divisor, latched at issue
//   div_result  divider -> controller  {remainder, quotient}
//   div_ready   divider -> controller  result valid
//
// Handshake: div_start is the request and stays high from launch until the
// cycle div_ready is seen. div_ready plays the role of "valid": the result
// on div_result transfers in the cycle div_ready is high while the
// controller is waiting. The controller then drops div_start, which releases
// the divider back to idle. div_annul is a one-cycle pulse and is never high
// together with div_start.
//
// Modports: master = controller side, slave = divider side.
// ---------------------------------------------------------------------------
interface div_ctrl_if;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_ready;

    modport master (
        output div_start,
        output div_annul,
        output div_signed,
        output div_op1,
        output div_op2,
        input  div_result,
        input  div_ready
    );

    modport slave (
        input  div_start,
        input  div_annul,
        input  div_signed,
        input  div_op1,
        input  div_op2,
        output div_result,
        output div_ready
    );
endinterface

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl : EX-stage issue/collect controller for the iterative divider.
//
// A DIV/DIVU in EX launches the divider, the pipeline is held until the
// result arrives, {HI, LO} are written, then the divider is allowed to
// return to idle. A flush annuls an in-flight division; a watchdog flags a
// divider that never answers.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   ex_div_valid    DIV/DIVU present in EX
//   ex_div_signed   1 = DIV, 0 = DIVU
//   ex_op1/ex_op2   dividend / divisor from EX
//   flush           kills the EX instruction
//   div             divider link (div_ctrl_if.master)
//   stall_req       freeze IF/ID/EX (combinational)
//   hilo_we         one-cycle HI/LO write strobe
//   hi_o / lo_o     remainder / quotient, registered
//   div_timeout     sticky watchdog error
//   dbg_state_o     current FSM state (0 IDLE, 1 BUSY, 2 DRAIN)
// ---------------------------------------------------------------------------
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        flush,
    div_ctrl_if.master  div,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_timeout,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [5:0] WD_LIMIT = 6'd63;

    state_e      state_q;
    logic [1:0]  drain_q;
    logic [5:0]  wd_q;
    logic        signed_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        timeout_q;

    logic        launch;
    logic        start_c;
    logic        annul_c;
    logic        stall_c;
    logic        we_c;

    // Cycle-level decode. Everything is forced low while rst is high so that
    // a DIV sitting in EX during reset neither stalls nor launches.
    always_comb begin
        launch  = 1'b0;
        start_c = 1'b0;
        annul_c = 1'b0;
        stall_c = 1'b0;
        we_c    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    launch  = ex_div_valid & ~flush;
                    start_c = launch;
                    stall_c = launch;
                end
                S_BUSY: begin
                    // Flush together with div_ready: flush wins, but the
                    // result is already there so no annul is needed.
                    annul_c = flush & ~div.div_ready;
                    start_c = ~annul_c;
                    we_c    = div.div_ready & ~flush;
                    stall_c = ~div.div_ready;
                end
                S_DRAIN: begin
                    // A following DIV must wait until the divider is free.
                    stall_c = ex_div_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            drain_q   <= 2'd0;
            wd_q      <= 6'd0;
            signed_q  <= 1'b0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // The watchdog is zero at launch and counts the launch
                    // cycle itself, so its value equals cycles since launch.
                    wd_q <= launch ? 6'd1 : 6'd0;
                    if (launch) begin
                        signed_q <= ex_div_signed;
                        op1_q    <= ex_op1;
                        op2_q    <= ex_op2;
                        state_q  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (wd_q != WD_LIMIT) begin
                        wd_q <= wd_q + 6'd1;
                    end
                    if (flush) begin
                        // An annulled divider walks through its zero-divide
                        // and end states, which needs one extra drain cycle.
                        state_q <= S_DRAIN;
                        drain_q <= div.div_ready ? 2'd1 : 2'd2;
                    end else if (div.div_ready) begin
                        hi_q    <= div.div_result[63:32];
                        lo_q    <= div.div_result[31:0];
                        state_q <= S_DRAIN;
                        drain_q <= 2'd1;
                    end else if (wd_q == WD_LIMIT - 6'd1) begin
                        // Counter reaches the limit at this edge while still
                        // waiting; keep waiting, just raise the error.
                        timeout_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    drain_q <= drain_q - 2'd1;
                    if (drain_q == 2'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    drain_q <= 2'd0;
                end
            endcase
        end
    end

    assign div.div_start  = start_c;
    assign div.div_annul  = annul_c;
    assign div.div_signed = signed_q;
    assign div.div_op1    = op1_q;
    assign div.div_op2    = op2_q;

    assign stall_req   = stall_c;
    assign hilo_we     = we_c;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign div_timeout = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
module tb_div_ctrl;

    // ------------------------------------------------------------------
    // clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        ex_div_valid  = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_op1        = 32'd0;
    logic [31:0] ex_op2        = 32'd0;
    logic        flush         = 1'b0;
    logic        stall_req;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_timeout;
    logic [1:0]  dbg_state;

    div_ctrl_if bus();

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .flush        (flush),
        .div          (bus),
        .stall_req    (stall_req),
        .hilo_we      (hilo_we),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_timeout  (div_timeout),
        .dbg_state_o  (dbg_state)
    );

    // ------------------------------------------------------------------
    // reference arithmetic: MIPS DIV/DIVU, x/0 returns 0/0
    // ------------------------------------------------------------------
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // ------------------------------------------------------------------
    // divider model: result 35 cycles after launch (3 for zero divisor),
    // returns to idle whenever start is low
    // ------------------------------------------------------------------
    int unsigned dv_cnt   = 0;
    bit          dv_run   = 1'b0;
    bit          dv_stuck = 1'b0;

    always @(posedge clk) begin
        if (rst || !bus.div_start) begin
            dv_run <= 1'b0;
            dv_cnt <= 0;
        end else begin
            dv_run <= 1'b1;
            dv_cnt <= dv_cnt + 1;
        end
    end

    assign bus.div_ready  = dv_run && !dv_stuck &&
                            (dv_cnt == ((bus.div_op2 == 32'd0) ? 32'd3 : 32'd35));
    assign bus.div_result = bus.div_ready ? ref_div(bus.div_signed, bus.div_op1, bus.div_op2)
                                          : 64'hDEAD_BEEF_0BAD_F00D;

    // ------------------------------------------------------------------
    // scoreboard
    // ------------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_hilo = 64'd0;
    int          we_cyc    = 0;
    int          start_cyc = 0;
    int          annul_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // driver tasks
    // ------------------------------------------------------------------
    // One DIV from launch (k=0) through its drain cycles. flush_at < 0 means
    // no flush; flush_at == latency is the flush/ready collision.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit next_waiting,
                          input bit flush_in_drain, input logic [63:0] exp_res);
        int lat, last;
        bit annulled, completes;
        int n_start, first_start, last_start, n_stall, n_we, we_at, n_annul, annul_at, n_ovl;
        lat       = (b == 32'd0) ? 3 : 35;
        annulled  = (flush_at >= 1) && (flush_at < lat);
        completes = !((flush_at >= 1) && (flush_at <= lat));
        last      = annulled ? flush_at + 2 : lat + 1;
        n_start = 0; first_start = -1; last_start = -1; n_stall = 0;
        n_we = 0; we_at = -1; n_annul = 0; annul_at = -1; n_ovl = 0;
        if (completes) exp_q.push_back(exp_res);
        for (int k = 0; k <= last; k++) begin
            bit in_ex;
            @(negedge clk);
            in_ex         = (flush_at >= 0) ? (k <= flush_at) : (k <= lat);
            ex_div_valid  = in_ex ? 1'b1 : next_waiting;
            ex_div_signed = in_ex ? sgn : 1'b0;
            ex_op1        = in_ex ? a : $urandom;
            ex_op2        = in_ex ? b : $urandom;
            flush         = (k == flush_at) || (flush_in_drain && k == last);
            #1;
            if (bus.div_start) begin
                n_start++;
                last_start = k;
                if (first_start < 0) begin
                    first_start = k;
                    start_cyc   = cyc;
                end
            end
            if (stall_req) n_stall++;
            if (hilo_we) begin
                n_we++;
                we_at  = k;
                we_cyc = cyc;
            end
            if (bus.div_annul) begin
                n_annul++;
                annul_at  = k;
                annul_cyc = cyc;
            end
            if (bus.div_annul && bus.div_start) n_ovl++;
            if (k == 1) begin
                check("op1_latch", bus.div_op1, a);
                check("op2_latch", bus.div_op2, b);
                check("signed_latch", bus.div_signed, sgn);
            end
            if (completes && k == lat + 1) begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hilo_new", {hi_o, lo_o}, e);
                cur_hilo = e;
            end
            if (!completes && k == last) check("hilo_kept", {hi_o, lo_o}, cur_hilo);
        end
        check("start_first", first_start, 0);
        check("start_count", n_start, annulled ? flush_at : lat + 1);
        check("start_last", last_start, annulled ? flush_at - 1 : lat);
        check("stall_count", n_stall,
              (annulled ? flush_at + 1 : lat) + (annulled ? 2 : 1) * int'(next_waiting));
        check("we_count", n_we, completes ? 1 : 0);
        if (completes) check("we_cycle", we_at, lat);
        check("annul_count", n_annul, annulled ? 1 : 0);
        if (annulled) check("annul_cycle", annul_at, flush_at);
        check("annul_with_start", n_ovl, 0);
        check("timeout_clear", div_timeout, 1'b0);
    endtask

    task automatic idle_cycles(input int n, input bit valid, input bit fl);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ex_div_valid  = valid;
            flush         = fl;
            ex_div_signed = 1'b0;
            ex_op1        = $urandom;
            ex_op2        = $urandom;
            #1;
            check("idle_start", bus.div_start, 1'b0);
            check("idle_stall", stall_req, 1'b0);
            check("idle_state", dbg_state, 2'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall_req, 1'b0);
        check({tag, "_start"}, bus.div_start, 1'b0);
        check({tag, "_annul"}, bus.div_annul, 1'b0);
        check({tag, "_we"}, hilo_we, 1'b0);
        check({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
        check({tag, "_ops"}, {bus.div_op1, bus.div_op2}, 64'd0);
        check({tag, "_signed"}, bus.div_signed, 1'b0);
        check({tag, "_timeout"}, div_timeout, 1'b0);
        check({tag, "_state"}, dbg_state, 2'd0);
    endtask

    // Divider never answers: watchdog at T63, FSM keeps waiting, rst clears.
    task automatic stuck_run();
        int n_we;
        n_we = 0;
        for (int k = 0; k <= 70; k++) begin
            @(negedge clk);
            dv_stuck      = 1'b1;
            ex_div_valid  = 1'b1;
            ex_div_signed = 1'b1;
            ex_op1        = 32'd40;
            ex_op2        = 32'd8;
            flush         = 1'b0;
            #1;
            if (hilo_we) n_we++;
            if (k == 62) begin
                check("wd_before", div_timeout, 1'b0);
                check("wd_stall_62", stall_req, 1'b1);
            end
            if (k == 63) check("wd_at_63", div_timeout, 1'b1);
            if (k == 70) begin
                check("wd_sticky", div_timeout, 1'b1);
                check("wd_still_start", bus.div_start, 1'b1);
                check("wd_still_state", dbg_state, 2'd1);
            end
        end
        check("wd_no_write", n_we, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_comb_stall", stall_req, 1'b0);
        check("rst_comb_start", bus.div_start, 1'b0);
        @(negedge clk);
        #1;
        check_all_zero("rst_mid");
        cur_hilo = 64'd0;
        @(negedge clk);
        rst          = 1'b0;
        dv_stuck     = 1'b0;
        ex_div_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // main sequence
    // ------------------------------------------------------------------
    initial begin
        int w;
        rst          = 1'b1;
        ex_div_valid = 1'b1;
        ex_op1       = 32'd100;
        ex_op2       = 32'd7;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst          = 1'b0;
        ex_div_valid = 1'b0;

        // flush in IDLE: no launch
        idle_cycles(2, 1'b1, 1'b1);

        do_div(1'b0, 32'd100, 32'd7, -1, 1'b0, 1'b0, {32'd2, 32'd14});
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, 1'b0, {32'd1, 32'h7FFF_FFFC});
        do_div(1'b1, 32'd123, 32'd0, -1, 1'b0, 1'b0, 64'd0);

        // back-to-back: second launch two cycles after the first write
        do_div(1'b1, 32'd50, 32'd5, -1, 1'b1, 1'b0, {32'd0, 32'd10});
        w = we_cyc;
        do_div(1'b1, 32'd9, 32'd4, -1, 1'b0, 1'b0, {32'd1, 32'd2});
        check("b2b_gap", start_cyc - w, 2);

        // flush at T10, next DIV waiting, relaunch at T13
        do_div(1'b0, 32'd1000, 32'd3, 10, 1'b1, 1'b0, 64'd0);
        w = annul_cyc;
        do_div(1'b1, 32'd77, 32'd8, -1, 1'b0, 1'b0, {32'd5, 32'd9});
        check("annul_relaunch_gap", start_cyc - w, 3);

        // flush together with div_ready: no write, no annul
        do_div(1'b0, 32'd20, 32'd6, 35, 1'b0, 1'b0, 64'd0);
        // flush during DRAIN has no effect
        do_div(1'b0, 32'd21, 32'd6, -1, 1'b0, 1'b1, {32'd3, 32'd3});

        for (int i = 0; i < 12; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          lat, fa;
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 :
                  (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 15)) : $urandom);
            lat = (b == 32'd0) ? 3 : 35;
            fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : -1;
            do_div(s, a, b, fa, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ref_div(s, a, b));
        end

        stuck_run();
        do_div(1'b0, 32'd1234, 32'd10, -1, 1'b0, 1'b0, {32'd4, 32'd123});

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL tb_time_limit: run still active, required finish before 500000ns");
        $fatal(1);
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

EX-stage issue/collect controller for the multi-cycle iterative divider. When a DIV/DIVU sits in EX, it launches the divider and holds the pipeline stalled until the result arrives. It then writes {HI, LO} and returns the divider to its idle state. On a pipeline flush it annuls an in-flight division, and it flags a divider that never completes.

## Interface
- No parameters. Fixed widths: 32-bit operands, 64-bit result. The watchdog limit is the constant 63.
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- ex_div_valid  in  1  DIV or DIVU instruction present in EX
- ex_div_signed  in  1  1 = DIV (signed), 0 = DIVU
- ex_op1  in  32  dividend (rs)
- ex_op2  in  32  divisor (rt)
- flush  in  1  exception/pipeline flush; kills the EX instruction
- div_result  in  64  divider result, {remainder, quotient}
- div_ready  in  1  divider result valid
- div_start  out  1  start request to divider (level, held)
- div_annul  out  1  cancel in-flight division (1-cycle pulse)
- div_signed  out  1  signed-divide select, latched at issue
- div_op1, div_op2  out  32 each  operands, latched at issue
- stall_req  out  1  freeze IF/ID/EX (combinational)
- hilo_we  out  1  1-cycle write strobe for HI/LO
- hi_o  out  32  remainder, registered
- lo_o  out  32  quotient, registered
- div_timeout  out  1  sticky watchdog error

## Operation
- The controller has three states: IDLE, BUSY and DRAIN. DRAIN uses a 2-bit drain counter.
- **IDLE**
  - Entered on ex_div_valid & !flush.
  - On entry: latch ex_op1, ex_op2 and ex_div_signed into the div_op1/div_op2/div_signed registers; drive div_start=1; set stall_req=1; clear the watchdog counter; go to BUSY.
  - Start is qualified by the raw ex_div_valid, not a registered copy.
- **BUSY**
  - div_start=1 throughout. stall_req = !div_ready.
  - Watchdog counter increments each cycle, saturating.
  - On div_ready=1 (and no flush):
    - hi_o <= div_result[63:32] and lo_o <= div_result[31:0], registered, so they update at the end of this cycle and are valid from the next.
    - hilo_we=1 this cycle and stall_req=0, so the instruction leaves EX at this edge. The HI/LO file captures hi_o/lo_o on the following cycle.
    - Go to DRAIN with drain=1.
- **DRAIN**
  - div_start=0, so the divider's End state sees stop and returns to free.
  - stall_req = ex_div_valid. A following DIV waits and is not launched.
  - When drain counts to 0, go to IDLE.
  - Normal completion needs 1 DRAIN cycle. Annul needs 2 DRAIN cycles, which covers the divider passing through its divide-by-zero and end states with start low.
- **Flush**
  - In BUSY, if div_ready=0:
    - div_annul=1 for this cycle only, div_start=0, no HI/LO write.
    - Go to DRAIN with drain=2.
  - In BUSY with div_ready=1 in the same cycle: flush wins. No write, no annul pulse, DRAIN with drain=1.
  - In IDLE: no launch.
  - In DRAIN: no effect.
- **Watchdog:** if the counter reaches 63 while in BUSY, set div_timeout=1. It stays set until rst. The FSM keeps waiting and does not force completion.
- **Divide by zero:** no special handling. The controller writes whatever the divider returns (0/0).
- **Reset values:**
  - State IDLE; drain counter 0; watchdog counter 0.
  - div_start=0, div_annul=0, div_signed=0, div_op1=0, div_op2=0.
  - stall_req=0 (since ex_div_valid is ignored during rst), hilo_we=0, hi_o=0, lo_o=0, div_timeout=0.
- **rst mid-operation:** return to IDLE immediately with the reset values above. The divider is reset by the same rst.

## Timing
- T0 = the IDLE cycle in which the launch happens (div_start first high).
- Nonzero divisor:
  - Divider runs 32 iterations plus 1 sign-fix cycle, then its End state.
  - div_ready is first high at T35, so hilo_we is high at T35.
  - hi_o/lo_o show the new values at T36.
  - stall_req is high T0..T34: 35 stall cycles.
- Zero divisor: div_ready at T3; hilo_we at T3.
- Back-to-back DIV: the second launch is at T37 (DRAIN at T36, IDLE launch at T37), with stall continuous from T36.
- Annul at cycle Tf: div_annul=1 at Tf; DRAIN at Tf+1 and Tf+2; a new launch is possible at Tf+3.
- div_annul is never high together with div_start.
- hilo_we never fires twice per launch.

## Test plan
- DIVU 100/7 -> div_start high T0..T35; hilo_we only at T35; hi_o=2, lo_o=14 from T36; stall_req high T0..T34.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; DIVU on the same operands -> lo_o=0x7FFFFFFC, hi_o=1.
- DIV x/0 -> hilo_we at T3; hi_o=lo_o=0; no timeout.
- Two consecutive DIVs (50/5 then 9/4) -> second div_start rises exactly 2 cycles after the first hilo_we; final hi_o=1, lo_o=2; stall has no gap between the two.
- flush at T10 -> div_annul pulse at T10 only; no hilo_we; hi_o/lo_o keep their old values; a new DIV launches no earlier than T13 and completes correctly.
- Divider model holding div_ready=0 -> div_timeout=1 at T63 and stays set; rst then clears all outputs to 0 and the FSM to IDLE.
